// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB CRC memory slave.
// Holds the FSM state enum, lane merge and top-byte XOR helpers.
package apb_mem_pkg;

  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  // XOR of bytes 0..nb-2; the top byte of an nb-byte word is the check byte.
  function automatic logic [7:0] crc_byte(
    input logic [MAX_DW-1:0] w,
    input int                nb
  );
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      if (i < nb - 1) x ^= w[i*8 +: 8];
    end
    return x;
  endfunction

  function automatic logic [MAX_DW-1:0] strb_merge(
    input logic [MAX_DW-1:0] wd,
    input logic [MAX_DW-1:0] od,
    input logic [MAX_NB-1:0] s
  );
    logic [MAX_DW-1:0] m;
    for (int i = 0; i < MAX_NB; i++) begin
      m[i*8 +: 8] = s[i] ? wd[i*8 +: 8] : od[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/apb_crc_chk.sv
// Byte-lane merge of write data over the stored word plus top-byte check.
// Ports: wdata/old/strb in; merged word and crc_ok out. Purely combinational.
module apb_crc_chk
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   old,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged,
  output logic                    crc_ok
);

  localparam int NB = DATA_WIDTH / 8;

  assign merged = DATA_WIDTH'(strb_merge(
    MAX_DW'(wdata), MAX_DW'(old), MAX_NB'(strb)));

  assign crc_ok =
    merged[DATA_WIDTH-1 -: 8] == crc_byte(MAX_DW'(merged), NB);

endmodule

// File: rtl/apb_crc_mem_slave.sv
// APB4 word memory with wait states, strobes, top-byte XOR check, error count.
// Ports: clk, rst (async low), APB addr/prot/sel/enable/wr_rd/wdata/strb; ready/rdata/err/err_cnt.
module apb_crc_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 2**ADDR_WIDTH,
  parameter int WAIT_STATES = 0,
  parameter int CRC_EN      = 1,
  parameter int PRIV_ONLY   = 0,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [2:0]              prot,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    wr_rd,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] merged;
  logic                  crc_ok;
  logic                  oob;
  logic                  priv_bad;
  logic                  crc_bad;
  logic                  unused_ok;

  assign unused_ok = &{1'b0, prot[2:1]};

  assign oob      = 32'(addr) >= DEPTH;
  assign priv_bad = (PRIV_ONLY != 0) && !prot[0];
  // Out-of-range addresses never index the array.
  assign cur      = oob ? '0 : mem[addr];

  apb_crc_chk #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_chk (
    .wdata (wdata),
    .old   (cur),
    .strb  (strb),
    .merged(merged),
    .crc_ok(crc_ok)
  );

  assign crc_bad = wr_rd && (CRC_EN != 0) && !crc_ok;

  assign ready = (state == ACCESS) && sel && enable && (cnt == WS);
  assign err   = ready && (oob || priv_bad || crc_bad);
  assign rdata = (ready && !err && !wr_rd) ? cur : '0;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (sel) begin
          state_nx = ACCESS;
          cnt_nx   = '0;
        end
      end
      ACCESS: begin
        // Dropping sel before completion aborts the transfer.
        if (!sel || ready) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt < WS) begin
          cnt_nx = cnt + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ready && wr_rd && !err) begin
      mem[addr] <= merged;
    end
  end

endmodule
